// File: rtl/mmio_pkg.sv
// Shared types and constants for the mmio_bus interconnect.
// Contents: FSM state type, access target type, latched request payload,
// GPIO register offsets, field widths and the region address-match helper.
package mmio_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned SIZE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    TGT_MISS,
    TGT_GPIO,
    TGT_REGION
  } tgt_t;

  // GPIO register offsets, selected by addr[3:2]
  localparam logic [1:0] GPIO_OFF_DATA   = 2'd0;
  localparam logic [1:0] GPIO_OFF_SET    = 2'd1;
  localparam logic [1:0] GPIO_OFF_CLR    = 2'd2;
  localparam logic [1:0] GPIO_OFF_TOGGLE = 2'd3;

  // Request fields captured at accept time and held until the response
  typedef struct packed {
    logic              read;
    tgt_t              tgt;
    logic [1:0]        off;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // A region is size-aligned, so a match is an equal prefix above the size bits
  function automatic logic region_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [SIZE_W-1:0] size);
    return (addr >> size) == (base >> size);
  endfunction

endpackage

// File: rtl/mmio_gpio.sv
// GPIO register bank with DATA / SET / CLR / TOGGLE write semantics.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   we          write strobe (one cycle)
//   off         register offset (addr[3:2])
//   wdata       write data, GPIO_W bits
//   data        current register value
//   gpio_out    pin drive, inverted when GPIO_ACTIVE_LOW
module mmio_gpio
  import mmio_pkg::*;
#(
  parameter int unsigned       GPIO_W          = 6,
  parameter logic [GPIO_W-1:0] GPIO_INIT       = '0,
  parameter bit                GPIO_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        off,
  input  logic [GPIO_W-1:0] wdata,
  output logic [GPIO_W-1:0] data,
  output logic [GPIO_W-1:0] gpio_out
);

  logic [GPIO_W-1:0] data_nxt;

  // Write-operation decode
  always_comb begin
    data_nxt = data;
    if (we) begin
      case (off)
        GPIO_OFF_DATA:   data_nxt = wdata;
        GPIO_OFF_SET:    data_nxt = data | wdata;
        GPIO_OFF_CLR:    data_nxt = data & ~wdata;
        GPIO_OFF_TOGGLE: data_nxt = data ^ wdata;
        default:         data_nxt = data;
      endcase
    end
  end

  // Pins are registered from the next value so they move with the data register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data     <= GPIO_INIT;
      gpio_out <= GPIO_ACTIVE_LOW ? ~GPIO_INIT : GPIO_INIT;
    end else begin
      data     <= data_nxt;
      gpio_out <= GPIO_ACTIVE_LOW ? ~data_nxt : data_nxt;
    end
  end

endmodule

// File: rtl/mmio_bus.sv
// Memory-mapped interconnect between the CPU data port and its peripherals.
// Decodes an access to the built-in GPIO bank, one of NUM_REGIONS slave
// regions (with per-region wait states) or a miss, and returns a one-cycle
// cpu_ready pulse. Optional error reporting is enabled by defining
// MMIO_ERR_EN (miss and misaligned accesses raise cpu_err).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpu_en/read/addr/wdata          CPU request, held until cpu_ready
//   cpu_rdata/ready/err             response, valid for the cpu_ready cycle
//   slv_sel/we/addr/wdata           one-cycle slave access strobe and payload
//   slv_rdata                       flat slave read data, 32 bits per region
//   gpio_out                        GPIO pins
module mmio_bus
  import mmio_pkg::*;
#(
  parameter int unsigned                   NUM_REGIONS      = 3,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE      = {32'h200, 32'h100, 32'h0},
  parameter logic [NUM_REGIONS*SIZE_W-1:0] REGION_SIZE_LOG2 = {8'd8, 8'd8, 8'd8},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT      = {4'd1, 4'd1, 4'd0},
  parameter logic [ADDR_W-1:0]             GPIO_BASE        = 32'h400,
  parameter int unsigned                   GPIO_W           = 6,
  parameter logic [31:0]                   GPIO_INIT        = 32'h0,
  parameter bit                            GPIO_ACTIVE_LOW  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_en,
  input  logic                          cpu_read,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_ready,
  output logic                          cpu_err,
  output logic [NUM_REGIONS-1:0]        slv_sel,
  output logic                          slv_we,
  output logic [ADDR_W-1:0]             slv_addr,
  output logic [DATA_W-1:0]             slv_wdata,
  input  logic [NUM_REGIONS*DATA_W-1:0] slv_rdata,
  output logic [GPIO_W-1:0]             gpio_out
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

`ifdef MMIO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_t             state, state_nxt;
  req_t               req, req_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [WAIT_W-1:0]  cnt, cnt_nxt;
  logic [NUM_REGIONS-1:0] sel_nxt;
  logic               we_nxt;
  logic [ADDR_W-1:0]  slv_addr_nxt;
  logic               ready_nxt;
  logic               err_nxt;
  logic [DATA_W-1:0]  rdata_nxt;

  logic               hit_gpio_c;
  logic               hit_region_c;
  logic [IDX_W-1:0]   hit_idx_c;
  logic               misalign_c;
  logic               gpio_we_c;
  logic [GPIO_W-1:0]  gpio_data;

  function automatic logic [ADDR_W-1:0] base_of(input logic [IDX_W-1:0] i);
    return REGION_BASE[ADDR_W*i +: ADDR_W];
  endfunction

  function automatic logic [WAIT_W-1:0] wait_of(input logic [IDX_W-1:0] i);
    return REGION_WAIT[WAIT_W*i +: WAIT_W];
  endfunction

  function automatic logic [DATA_W-1:0] rdata_of(input logic [IDX_W-1:0] i);
    return slv_rdata[DATA_W*i +: DATA_W];
  endfunction

  // Address decode: GPIO window first, then the lowest-index matching region
  always_comb begin
    hit_gpio_c   = (cpu_addr[ADDR_W-1:4] == GPIO_BASE[ADDR_W-1:4]);
    hit_region_c = 1'b0;
    hit_idx_c    = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!hit_region_c &&
          region_hit(cpu_addr, REGION_BASE[ADDR_W*i +: ADDR_W],
                     REGION_SIZE_LOG2[SIZE_W*i +: SIZE_W])) begin
        hit_region_c = 1'b1;
        hit_idx_c    = IDX_W'(i);
      end
    end
  end

  assign misalign_c = ERR_EN && (cpu_addr[1:0] != 2'b00);

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    req_nxt      = req;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    slv_addr_nxt = slv_addr;
    sel_nxt      = '0;
    we_nxt       = 1'b0;
    ready_nxt    = 1'b0;
    err_nxt      = 1'b0;
    rdata_nxt    = '0;
    gpio_we_c    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_en) begin
          req_nxt.read  = cpu_read;
          req_nxt.wdata = cpu_wdata;
          req_nxt.off   = cpu_addr[3:2];
          if (misalign_c) begin
            // Rejected outright: nothing forwarded, GPIO untouched
            req_nxt.tgt = TGT_MISS;
            state_nxt   = ST_RESP;
            ready_nxt   = 1'b1;
            err_nxt     = 1'b1;
          end else if (hit_gpio_c) begin
            req_nxt.tgt = TGT_GPIO;
            state_nxt   = ST_RESP;
            ready_nxt   = 1'b1;
            rdata_nxt   = cpu_read ? DATA_W'(gpio_data) : '0;
          end else if (hit_region_c) begin
            req_nxt.tgt  = TGT_REGION;
            idx_nxt      = hit_idx_c;
            slv_addr_nxt = cpu_addr - base_of(hit_idx_c);
            sel_nxt      = NUM_REGIONS'(1) << hit_idx_c;
            we_nxt       = !cpu_read;
            state_nxt    = ST_ACCESS;
          end else begin
            req_nxt.tgt = TGT_MISS;
            state_nxt   = ST_RESP;
            ready_nxt   = 1'b1;
            err_nxt     = ERR_EN;
          end
        end
      end

      ST_ACCESS: begin
        cnt_nxt = wait_of(idx);
        if (wait_of(idx) != '0) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_RESP;
          ready_nxt = 1'b1;
          rdata_nxt = req.read ? rdata_of(idx) : '0;
        end
      end

      ST_WAIT: begin
        if (cnt <= WAIT_W'(1)) begin
          state_nxt = ST_RESP;
          ready_nxt = 1'b1;
          rdata_nxt = req.read ? rdata_of(idx) : '0;
        end else begin
          cnt_nxt = cnt - WAIT_W'(1);
        end
      end

      ST_RESP: begin
        state_nxt = ST_IDLE;
        gpio_we_c = (req.tgt == TGT_GPIO) && !req.read;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Latched request and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req       <= '0;
      idx       <= '0;
      cnt       <= '0;
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      req       <= req_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      slv_sel   <= sel_nxt;
      slv_we    <= we_nxt;
      slv_addr  <= slv_addr_nxt;
      cpu_ready <= ready_nxt;
      cpu_err   <= err_nxt;
      cpu_rdata <= rdata_nxt;
    end
  end

  assign slv_wdata = req.wdata;

  mmio_gpio #(
    .GPIO_W          (GPIO_W),
    .GPIO_INIT       (GPIO_W'(GPIO_INIT)),
    .GPIO_ACTIVE_LOW (GPIO_ACTIVE_LOW)
  ) u_gpio (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (gpio_we_c),
    .off      (req.off),
    .wdata    (req.wdata[GPIO_W-1:0]),
    .data     (gpio_data),
    .gpio_out (gpio_out)
  );

endmodule

// File: tb/tb_mmio_bus.sv
// Self-checking bench for mmio_bus with default parameters.
module tb_mmio_bus;

`ifdef MMIO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [31:0] RB [3] = '{32'h0, 32'h100, 32'h200};
  localparam int          RS [3] = '{8, 8, 8};
  localparam int          RW [3] = '{0, 1, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en, cpu_read;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [2:0]  slv_sel;
  logic        slv_we;
  logic [31:0] slv_addr, slv_wdata;
  logic [95:0] slv_rdata;
  logic [5:0]  gpio_out;
  logic [31:0] slv_word [3];

  assign slv_rdata = {slv_word[2], slv_word[1], slv_word[0]};

  always #5 clk = ~clk;

  mmio_bus dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .cpu_read(cpu_read),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .slv_sel(slv_sel),
    .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .gpio_out(gpio_out)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Observations from the last transfer
  int          got_lat, got_sel_cycles;
  logic [31:0] got_rdata, got_saddr, got_swd;
  logic        got_err, got_we, got_ready_after;
  logic [2:0]  got_sel;
  logic [5:0]  got_gpio_ready;

  // Reference model state and expectations
  logic [5:0]  m_gpio;
  int          exp_lat;
  logic [31:0] exp_rdata, exp_saddr;
  logic        exp_err, exp_we;
  logic [2:0]  exp_sel;

  // Drives one request starting at a negedge; ends at a negedge with the bus idle
  task automatic xfer(input logic rd, input logic [31:0] a, input logic [31:0] wd);
    cpu_en = 1'b1; cpu_read = rd; cpu_addr = a; cpu_wdata = wd;
    got_lat = -1; got_sel = '0; got_sel_cycles = 0; got_we = 1'b0;
    got_saddr = '0; got_swd = '0; got_rdata = '0; got_err = 1'b0;
    got_gpio_ready = gpio_out; got_ready_after = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (slv_sel != 3'b000) begin
        got_sel_cycles++;
        got_sel   = got_sel | slv_sel;
        got_we    = slv_we;
        got_saddr = slv_addr;
        got_swd   = slv_wdata;
      end
      if (cpu_ready) begin
        got_lat = k; got_rdata = cpu_rdata; got_err = cpu_err; got_gpio_ready = gpio_out;
        break;
      end
    end
    cpu_en = 1'b0; cpu_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got_ready_after = cpu_ready;
  endtask

  // Behavioural expectation for one access; updates the GPIO model on writes
  task automatic predict(input logic rd, input logic [31:0] a, input logic [31:0] wd);
    int r;
    int off;
    r = -1;
    exp_lat = 1; exp_rdata = '0; exp_saddr = '0; exp_err = 1'b0; exp_we = 1'b0; exp_sel = '0;
    if (ERR_EN && (a % 4) != 0) begin
      exp_err = 1'b1;
      return;
    end
    if (a >= 32'h400 && a < 32'h410) begin
      off = int'((a - 32'h400) / 4);
      if (rd) exp_rdata = {26'd0, m_gpio};
      else if (off == 0) m_gpio = wd[5:0];
      else if (off == 1) m_gpio = m_gpio | wd[5:0];
      else if (off == 2) m_gpio = m_gpio & ~wd[5:0];
      else               m_gpio = m_gpio ^ wd[5:0];
      return;
    end
    for (int i = 0; i < 3; i++)
      if (r < 0 && a >= RB[i] && a < RB[i] + (32'd1 << RS[i])) r = i;
    if (r >= 0) begin
      exp_lat   = 2 + RW[r];
      exp_sel   = 3'(1 << r);
      exp_saddr = a - RB[r];
      exp_we    = !rd;
      exp_rdata = rd ? slv_word[r] : 32'h0;
      return;
    end
    exp_err = ERR_EN;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cpu_en = 1'b0; cpu_read = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    m_gpio = 6'h00;
    n_checks++; if (gpio_out !== 6'h3F) begin n_err++; $display("FAIL reset_gpio: got %h want 3f", gpio_out); end
    n_checks++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
    n_checks++; if (slv_sel !== 3'b000) begin n_err++; $display("FAIL reset_sel: got %b want 000", slv_sel); end
    n_checks++; if (cpu_rdata !== 32'h0 || cpu_err !== 1'b0 || slv_we !== 1'b0) begin
      n_err++; $display("FAIL reset_misc: rdata %h err %b we %b want 0", cpu_rdata, cpu_err, slv_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gpio_seq;
    logic [31:0] ga [4] = '{32'h400, 32'h404, 32'h408, 32'h40C};
    logic [31:0] gw [4] = '{32'h05, 32'h10, 32'h01, 32'h3F};
    logic [5:0]  gd [4] = '{6'h05, 6'h15, 6'h14, 6'h2B};
    logic [5:0]  prev;
    for (int i = 0; i < 4; i++) begin
      prev = gpio_out;
      predict(1'b0, ga[i], gw[i]);
      xfer(1'b0, ga[i], gw[i]);
      n_checks++; if (got_lat !== 1) begin n_err++; $display("FAIL gpio_lat[%0d]: got %0d want 1", i, got_lat); end
      n_checks++; if (got_gpio_ready !== prev) begin n_err++; $display("FAIL gpio_early[%0d]: got %h want %h", i, got_gpio_ready, prev); end
      n_checks++; if (gpio_out !== ~gd[i]) begin n_err++; $display("FAIL gpio_out[%0d]: got %h want %h", i, gpio_out, ~gd[i]); end
      n_checks++; if (got_ready_after !== 1'b0 || got_err !== 1'b0) begin
        n_err++; $display("FAIL gpio_pulse[%0d]: ready_after %b err %b want 0 0", i, got_ready_after, got_err);
      end
    end
    predict(1'b1, 32'h400, 32'h0);
    xfer(1'b1, 32'h400, 32'h0);
    n_checks++; if (got_rdata !== 32'h2B) begin n_err++; $display("FAIL gpio_read: got %h want 0000002b", got_rdata); end
    n_checks++; if (got_lat !== 1) begin n_err++; $display("FAIL gpio_read_lat: got %0d want 1", got_lat); end
  endtask

  task automatic test_region_read;
    slv_word[0] = 32'h11111111; slv_word[1] = 32'hDEADBEEF; slv_word[2] = 32'h22222222;
    xfer(1'b1, 32'h104, 32'h0);
    n_checks++; if (got_sel !== 3'b010 || got_sel_cycles !== 1) begin
      n_err++; $display("FAIL rd_sel: got %b x%0d want 010 x1", got_sel, got_sel_cycles);
    end
    n_checks++; if (got_saddr !== 32'h4) begin n_err++; $display("FAIL rd_saddr: got %h want 4", got_saddr); end
    n_checks++; if (got_lat !== 3) begin n_err++; $display("FAIL rd_lat: got %0d want 3", got_lat); end
    n_checks++; if (got_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", got_rdata); end
    n_checks++; if (got_we !== 1'b0) begin n_err++; $display("FAIL rd_we: got %b want 0", got_we); end
  endtask

  task automatic test_region_write;
    xfer(1'b0, 32'h10, 32'h1234);
    n_checks++; if (got_sel !== 3'b001 || got_sel_cycles !== 1) begin
      n_err++; $display("FAIL wr_sel: got %b x%0d want 001 x1", got_sel, got_sel_cycles);
    end
    n_checks++; if (got_we !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b want 1", got_we); end
    n_checks++; if (got_swd !== 32'h1234 || got_saddr !== 32'h10) begin
      n_err++; $display("FAIL wr_payload: wdata %h addr %h want 1234 10", got_swd, got_saddr);
    end
    n_checks++; if (got_lat !== 2) begin n_err++; $display("FAIL wr_lat: got %0d want 2", got_lat); end
    n_checks++; if (got_rdata !== 32'h0) begin n_err++; $display("FAIL wr_rdata: got %h want 0", got_rdata); end
  endtask

  task automatic test_miss;
    logic [5:0] prev;
    xfer(1'b1, 32'h800, 32'h0);
    n_checks++; if (got_lat !== 1 || got_sel_cycles !== 0) begin
      n_err++; $display("FAIL miss_lat: lat %0d sel_cycles %0d want 1 0", got_lat, got_sel_cycles);
    end
    n_checks++; if (got_err !== ERR_EN || got_rdata !== 32'h0) begin
      n_err++; $display("FAIL miss_resp: err %b rdata %h want %b 0", got_err, got_rdata, ERR_EN);
    end
    prev = gpio_out;
    xfer(1'b0, 32'h800, 32'hFFFF_FFFF);
    n_checks++; if (gpio_out !== prev || got_sel_cycles !== 0) begin
      n_err++; $display("FAIL miss_write: gpio %h sel_cycles %0d want %h 0", gpio_out, got_sel_cycles, prev);
    end
  endtask

  task automatic test_misaligned;
    logic [5:0] prev;
    prev = gpio_out;
    predict(1'b0, 32'h402, 32'h3F);
    xfer(1'b0, 32'h402, 32'h3F);
    n_checks++; if (got_err !== ERR_EN) begin n_err++; $display("FAIL mis_err: got %b want %b", got_err, ERR_EN); end
    n_checks++; if (gpio_out !== ~m_gpio) begin n_err++; $display("FAIL mis_gpio: got %h want %h (before %h)", gpio_out, ~m_gpio, prev); end
  endtask

  task automatic test_random;
    logic        rd;
    logic [31:0] a, wd;
    int          k, r;
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < 3; i++) slv_word[i] = $urandom;
      rd = 1'($urandom_range(0, 1));
      wd = $urandom;
      k  = $urandom_range(0, 4);
      r  = $urandom_range(0, 2);
      case (k)
        0:       a = 32'h400 + 32'($urandom_range(0, 3)) * 4;
        1, 2:    a = RB[r] + 32'($urandom_range(0, 63)) * 4;
        3:       a = 32'h1000 + 32'($urandom_range(0, 4095)) * 4;
        default: a = (r == 0) ? 32'h400 + 32'($urandom_range(0, 15)) : RB[r] + 32'($urandom_range(0, 255));
      endcase
      predict(rd, a, wd);
      xfer(rd, a, wd);
      n_checks++; if (got_lat !== exp_lat) begin n_err++; $display("FAIL rnd_lat[%0d] a=%h: got %0d want %0d", n, a, got_lat, exp_lat); end
      n_checks++; if (got_rdata !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata[%0d] a=%h: got %h want %h", n, a, got_rdata, exp_rdata); end
      n_checks++; if (got_err !== exp_err) begin n_err++; $display("FAIL rnd_err[%0d] a=%h: got %b want %b", n, a, got_err, exp_err); end
      n_checks++; if (got_sel !== exp_sel || got_sel_cycles !== ((exp_sel != 0) ? 1 : 0)) begin
        n_err++; $display("FAIL rnd_sel[%0d] a=%h: got %b x%0d want %b", n, a, got_sel, got_sel_cycles, exp_sel);
      end
      if (exp_sel != 3'b000) begin
        n_checks++; if (got_saddr !== exp_saddr || got_we !== exp_we || (!rd && got_swd !== wd)) begin
          n_err++; $display("FAIL rnd_slv[%0d] a=%h: addr %h we %b wdata %h want %h %b %h", n, a, got_saddr, got_we, got_swd, exp_saddr, exp_we, wd);
        end
      end
      n_checks++; if (gpio_out !== ~m_gpio) begin n_err++; $display("FAIL rnd_gpio[%0d] a=%h: got %h want %h", n, a, gpio_out, ~m_gpio); end
    end
  endtask

  task automatic test_reset_in_wait;
    predict(1'b0, 32'h400, 32'h3C);
    xfer(1'b0, 32'h400, 32'h3C);
    slv_word[1] = 32'hCAFEF00D;
    cpu_en = 1'b1; cpu_read = 1'b1; cpu_addr = 32'h108; cpu_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (slv_sel !== 3'b010) begin n_err++; $display("FAIL rw_access: sel %b want 010", slv_sel); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_gpio = 6'h00;
    n_checks++; if (cpu_ready !== 1'b0 || slv_sel !== 3'b000) begin
      n_err++; $display("FAIL rw_abort: ready %b sel %b want 0 000", cpu_ready, slv_sel);
    end
    n_checks++; if (gpio_out !== 6'h3F) begin n_err++; $display("FAIL rw_gpio: got %h want 3f", gpio_out); end
    cpu_en = 1'b0; cpu_read = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL rw_noready: got %b want 0", cpu_ready); end
    predict(1'b0, 32'h400, 32'h2A);
    xfer(1'b0, 32'h400, 32'h2A);
    n_checks++; if (got_lat !== 1 || gpio_out !== 6'h15) begin
      n_err++; $display("FAIL rw_fresh: lat %0d gpio %h want 1 15", got_lat, gpio_out);
    end
  endtask

  initial begin
    slv_word[0] = '0; slv_word[1] = '0; slv_word[2] = '0;
    test_reset();
    test_gpio_seq();
    test_region_read();
    test_region_write();
    test_miss();
    test_misaligned();
    test_random();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_bus.md
Name: mmio_bus

Overview:
- Parametrised memory-mapped interconnect between the furv core data port and its peripherals.
- Replaces hard-wired address compares and the single LED write register.
- Decodes the address into N slave regions, each with programmable wait states.
- Adds a handshake (cpu_ready), a miss/error response, and a built-in GPIO bank with SET/CLR/TOGGLE registers.

Parameters:
- NUM_REGIONS, 3: number of external slave regions.
- REGION_BASE, {32'h200,32'h100,32'h0}: flat NUM_REGIONS*32 vector; region i occupies bits [32*i+31:32*i].
- REGION_SIZE_LOG2, {8'd8,8'd8,8'd8}: flat NUM_REGIONS*8 vector; region size is 2**n bytes, and the base is aligned to that size.
- REGION_WAIT, {4'd1,4'd1,4'd0}: flat NUM_REGIONS*4 vector; extra wait cycles per region.
- GPIO_BASE, 32'h400: base address of the 16-byte GPIO window.
- GPIO_W, 6: GPIO width (1..32).
- GPIO_INIT, 0: GPIO data value after reset.
- GPIO_ACTIVE_LOW, 1: when 1, gpio_out = ~data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- cpu_en  in  1  access request
- cpu_read  in  1  1 = read, 0 = write
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data; valid while cpu_ready is high
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  error flag; valid with cpu_ready
- slv_sel  out  NUM_REGIONS  one-hot slave select
- slv_we  out  1  slave write strobe; qualified by slv_sel
- slv_addr  out  32  offset within the region (cpu_addr - base)
- slv_wdata  out  32  slave write data
- slv_rdata  in  32*NUM_REGIONS  flat slave read data
- gpio_out  out  GPIO_W  GPIO pins

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE.
  - cpu_ready, cpu_err, slv_sel, slv_we = 0; cpu_rdata = 0.
  - GPIO data = GPIO_INIT.
  - Reset takes priority over any access in flight; no ready pulse is issued for an aborted access.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - On cpu_en = 1, latch addr, wdata, read and decode result.
  - Decode priority: GPIO window (addr[31:4] == GPIO_BASE[31:4]) first, then the lowest-index region where (addr >> size) == (base >> size).
  - Miss -> RESP. GPIO hit -> RESP. Region hit -> ACCESS.
- ACCESS:
  - slv_sel[i] = 1 and slv_we = !read for exactly this one cycle.
  - slv_addr and slv_wdata are driven from the latched values.
  - Load the counter with REGION_WAIT[i]. Go to WAIT if nonzero, otherwise RESP.
- WAIT:
  - Counter decrements each cycle; go to RESP when it reaches 1.
  - Read data is sampled from slv_rdata[i] on the RESP transition.
  - Slaves hold read data stable from ACCESS until RESP.
- RESP:
  - cpu_ready = 1 for one cycle, then return to IDLE.
  - cpu_en is ignored outside IDLE; the CPU holds its request until cpu_ready.
  - A new request may be accepted in the cycle after RESP.
- Latency from the accept edge to cpu_ready:
  - GPIO or miss: 1 cycle.
  - Region i: 2 + REGION_WAIT[i] cycles.
- GPIO registers (offset addr[3:2]):
  - 0 DATA: write replaces data.
  - 1 SET: data |= wdata.
  - 2 CLR: data &= ~wdata.
  - 3 TOGGLE: data ^= wdata.
  - Only wdata[GPIO_W-1:0] is used.
  - A read at any offset returns DATA zero-extended.
  - Data updates on the RESP edge; gpio_out is registered and changes in the cycle after cpu_ready.
- Miss: writes are dropped and cpu_rdata = 0. Writes never put data on cpu_rdata (it reads 0).

Optional Feature:
- MMIO_ERR_EN defined:
  - cpu_err = 1 with cpu_ready on a miss.
  - cpu_err = 1 on a misaligned access (addr[1:0] != 0) to any target; the access is not forwarded and GPIO is unchanged.
- Not defined: cpu_err is tied to 0, misaligned addresses are forwarded unchanged, and misses complete silently.

Decomposition:
- Package mmio_pkg holds:
  - the FSM state typedef;
  - GPIO offset constants (DATA = 0, SET = 1, CLR = 2, TOGGLE = 3);
  - field widths (ADDR_W = 32, WAIT_W = 4, SIZE_W = 8).
- Sub-module mmio_gpio holds the GPIO register bank. It takes write strobe, offset and wdata, and outputs data and gpio_out.

Test Plan:
- Reset -> gpio_out = 6'h3F; cpu_ready = 0; slv_sel = 0.
- Write sequence, each with cpu_ready exactly 1 cycle after accept:
  - 0x05 to 0x400 -> gpio_out = 6'h3A.
  - SET 0x404 with 0x10 -> data 0x15.
  - CLR 0x408 with 0x01 -> data 0x14.
  - TOGGLE 0x40C with 0x3F -> data 0x2B.
  - Read 0x400 -> cpu_rdata = 0x2B.
- Read 0x104 with slv_rdata[1] = 0xDEADBEEF -> slv_sel = 3'b010 for one cycle, slv_addr = 4, cpu_ready 3 cycles after accept, cpu_rdata = 0xDEADBEEF.
- Write 0x10 with 0x1234 -> slv_sel = 3'b001, slv_we = 1, slv_wdata = 0x1234, cpu_ready 2 cycles after accept.
- With MMIO_ERR_EN:
  - Access 0x800 -> cpu_ready plus cpu_err after 1 cycle, cpu_rdata = 0, no slv_sel.
  - Write 0x402 -> cpu_err = 1, GPIO unchanged.
- rst_n = 0 while in WAIT for a region-1 read -> next cycle IDLE, no cpu_ready, gpio_out = 6'h3F. A fresh request after reset completes normally.
